// File: rtl/weight_stream_prefetcher.sv
// Weight stream prefetcher: splits a long SDRAM fetch into credit-gated
// bursts and replays the returned beats as a valid/ready stream.
module weight_stream_prefetcher #(
    parameter int DATA_W     = 128,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [31:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       read_addr,
    output logic [10:0]       read_cnt,
    output logic              read_start,
    input  logic              read_valid,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] STEP = 32'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       read_addr_q, read_addr_d;
    logic [10:0]       read_cnt_q, read_cnt_d;
    logic              read_start_q, read_start_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]     burst_q, burst_d;
    logic [CW-1:0]     used_q, used_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [CW-1:0]     burst;
    logic              push, pop, issue;

    assign burst = (rem_q < LEN_W'(MAX_BURST)) ? CW'(rem_q) : CW'(MAX_BURST);
    assign push  = (state_q == WAIT) && read_valid;
    assign pop   = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        len_d        = len_q;
        burst_d      = burst_q;
        read_addr_d  = read_addr_q;
        read_cnt_d   = read_cnt_q;
        read_start_d = 1'b0;
        done_d       = 1'b0;
        issue        = 1'b0;
        pop_cnt_d    = pop_cnt_q + LEN_W'(pop);
        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    len_d     = cmd_len;
                    rem_d     = cmd_len;
                    addr_d    = cmd_addr;
                    pop_cnt_d = '0;
                    if (cmd_len == '0) done_d = 1'b1;
                    else state_d = ISSUE;
                end
            end
            ISSUE: begin
                // used_q counts buffered beats plus beats still in flight
                if (CW'(FIFO_DEPTH) - used_q >= burst) begin
                    issue        = 1'b1;
                    read_start_d = 1'b1;
                    read_addr_d  = addr_q;
                    read_cnt_d   = 11'(burst);
                    burst_d      = burst;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (read_done) begin
                    addr_d = addr_q + 32'(burst_q) * STEP;
                    rem_d  = rem_q - LEN_W'(burst_q);
                    if (rem_d != '0) begin
                        state_d = ISSUE;
                    end else if (pop_cnt_d == len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_cnt_d == len_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        used_d   = used_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (issue) used_d = used_d + burst;
        if (pop)   used_d = used_d - CW'(1);
        if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            read_addr_q  <= '0;
            read_cnt_q   <= '0;
            read_start_q <= 1'b0;
            done_q       <= 1'b0;
            len_q        <= '0;
            rem_q        <= '0;
            pop_cnt_q    <= '0;
            burst_q      <= '0;
            used_q       <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            read_addr_q  <= read_addr_d;
            read_cnt_q   <= read_cnt_d;
            read_start_q <= read_start_d;
            done_q       <= done_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            pop_cnt_q    <= pop_cnt_d;
            burst_q      <= burst_d;
            used_q       <= used_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= read_data;
    end

    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign read_addr  = read_addr_q;
    assign read_cnt   = read_cnt_q;
    assign read_start = read_start_q;
    assign out_valid  = count_q != '0;
    assign out_data   = mem_q[rd_ptr_q];
    assign out_last   = out_valid && (pop_cnt_q == len_q - LEN_W'(1));

    push_not_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule
